// File: rtl/s2p_frame_ctrl_pkg.sv
// Shared s2p_frame_ctrl definitions: register MODO codes,
// controller state encoding and arbiter grant encoding.
package s2p_frame_ctrl_pkg;

  localparam logic [1:0] MODO_PUSH  = 2'b00;
  localparam logic [1:0] MODO_CYCLE = 2'b01;
  localparam logic [1:0] MODO_LOAD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_TX,
    ST_SHIFT_RX,
    ST_PAR,
    ST_DONE_RX
  } state_e;

  typedef enum logic {
    GRANT_TX = 1'b0,
    GRANT_RX = 1'b1
  } grant_e;

endpackage

// File: rtl/s2p_frame_ctrl_arb.sv
// Two-way round-robin arbiter between the TX and RX requesters;
// holds the side granted last so a tie goes to the other one.
module s2p_frame_arb
  import s2p_frame_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic tx_req,
  input  logic rx_req,
  output logic grant_tx,
  output logic grant_rx
);

  grant_e last_q, last_d;

  always_comb begin
    grant_tx = 1'b0;
    grant_rx = 1'b0;
    last_d   = last_q;
    if (en && tx_req && (!rx_req || last_q == GRANT_RX)) begin
      grant_tx = 1'b1;
      last_d   = GRANT_TX;
    end else if (en && rx_req) begin
      grant_rx = 1'b1;
      last_d   = GRANT_RX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= GRANT_RX;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/s2p_frame_ctrl.sv
// Half-duplex frame sequencer for one shared s2p_cond register.
// Optional parity bit: define S2P_FRAME_CTRL_PARITY_EN.
module s2p_frame_ctrl
  import s2p_frame_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             TX_VALID,
  input  logic [WIDTH-1:0] TX_DATA,
  output logic             TX_READY,
  input  logic             RX_REQ,
  output logic             RX_VALID,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             RX_PERR,
  input  logic             DIR_CFG,
  input  logic             SER_IN,
  output logic             SER_OUT,
  output logic             SER_OE,
  output logic             BUSY,
  output logic [WIDTH-1:0] SR_D,
  output logic [1:0]       SR_MODO,
  output logic             SR_ENB,
  output logic             SR_DIR,
  output logic             SR_S_IN,
  input  logic [WIDTH-1:0] SR_Q,
  input  logic             SR_S_OUT
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             dir_q, dir_d;
  logic             ser_oe_q, ser_oe_d;
  logic             rx_valid_q, rx_valid_d;
  logic             grant_tx, grant_rx, last_cnt;
`ifdef S2P_FRAME_CTRL_PARITY_EN
  logic             is_tx_q, is_tx_d;
  logic             par_bit_q, par_bit_d;
  logic             par_sel_q, par_sel_d;
  logic             rx_perr_q, rx_perr_d;
`endif

  s2p_frame_arb u_arb (
    .clk      (CLK),
    .rst_n    (RESET_L),
    .en       (state_q == ST_IDLE),
    .tx_req   (TX_VALID),
    .rx_req   (RX_REQ),
    .grant_tx (grant_tx),
    .grant_rx (grant_rx)
  );

  assign last_cnt = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_buf_d   = tx_buf_q;
    rx_data_d  = rx_data_q;
    dir_d      = dir_q;
    ser_oe_d   = 1'b0;
    rx_valid_d = 1'b0;
    SR_ENB     = 1'b0;
    SR_MODO    = MODO_LOAD;
    SR_S_IN    = 1'b0;
`ifdef S2P_FRAME_CTRL_PARITY_EN
    is_tx_d    = is_tx_q;
    par_bit_d  = par_bit_q;
    par_sel_d  = 1'b0;
    rx_perr_d  = rx_perr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (grant_tx) begin
          tx_buf_d = TX_DATA;
          dir_d    = DIR_CFG;
          state_d  = ST_LOAD;
`ifdef S2P_FRAME_CTRL_PARITY_EN
          is_tx_d  = 1'b1;
`endif
        end else if (grant_rx) begin
          dir_d    = DIR_CFG;
          cnt_d    = '0;
          state_d  = ST_SHIFT_RX;
`ifdef S2P_FRAME_CTRL_PARITY_EN
          is_tx_d  = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        SR_ENB  = 1'b1;
        cnt_d   = '0;
        state_d = ST_SHIFT_TX;
      end
      ST_SHIFT_TX: begin
        SR_ENB   = 1'b1;
        SR_MODO  = MODO_PUSH;
        ser_oe_d = 1'b1;
        cnt_d    = cnt_q + CW'(1);
        if (last_cnt) begin
`ifdef S2P_FRAME_CTRL_PARITY_EN
          state_d = ST_PAR;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      ST_SHIFT_RX: begin
        SR_ENB  = 1'b1;
        SR_MODO = MODO_PUSH;
        SR_S_IN = SER_IN;
        cnt_d   = cnt_q + CW'(1);
        if (last_cnt) begin
`ifdef S2P_FRAME_CTRL_PARITY_EN
          state_d = ST_PAR;
`else
          state_d = ST_DONE_RX;
`endif
        end
      end
      ST_PAR: begin
`ifdef S2P_FRAME_CTRL_PARITY_EN
        // TX: last data bit shows now, parity bit in the IDLE after
        if (is_tx_q) begin
          ser_oe_d  = 1'b1;
          par_sel_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          par_bit_d = SER_IN;
          state_d   = ST_DONE_RX;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE_RX: begin
        rx_data_d  = SR_Q;
        rx_valid_d = 1'b1;
        state_d    = ST_IDLE;
`ifdef S2P_FRAME_CTRL_PARITY_EN
        rx_perr_d  = par_bit_q ^ (^SR_Q);
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tx_buf_q   <= '0;
      rx_data_q  <= '0;
      dir_q      <= 1'b0;
      ser_oe_q   <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_buf_q   <= tx_buf_d;
      rx_data_q  <= rx_data_d;
      dir_q      <= dir_d;
      ser_oe_q   <= ser_oe_d;
      rx_valid_q <= rx_valid_d;
    end
  end

`ifdef S2P_FRAME_CTRL_PARITY_EN
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      is_tx_q   <= 1'b0;
      par_bit_q <= 1'b0;
      par_sel_q <= 1'b0;
      rx_perr_q <= 1'b0;
    end else begin
      is_tx_q   <= is_tx_d;
      par_bit_q <= par_bit_d;
      par_sel_q <= par_sel_d;
      rx_perr_q <= rx_perr_d;
    end
  end

  assign SER_OUT = par_sel_q ? ^tx_buf_q : SR_S_OUT;
  assign RX_PERR = rx_perr_q;
`else
  assign SER_OUT = SR_S_OUT;
  assign RX_PERR = 1'b0;
`endif

  assign TX_READY = grant_tx;
  assign RX_VALID = rx_valid_q;
  assign RX_DATA  = rx_data_q;
  assign SER_OE   = ser_oe_q;
  assign BUSY     = (state_q != ST_IDLE);
  assign SR_D     = tx_buf_q;
  assign SR_DIR   = dir_q;

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Bench for s2p_frame_ctrl with a behavioural s2p_cond register and
// a frame-timeline reference model; honours S2P_FRAME_CTRL_PARITY_EN.
module tb_s2p_frame_ctrl;
  import s2p_frame_ctrl_pkg::*;

  localparam int W = 8;
`ifdef S2P_FRAME_CTRL_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FL = W + 2 + P;

  logic         CLK = 1'b0;
  logic         RESET_L;
  logic         TX_VALID, TX_READY, RX_REQ, RX_VALID, RX_PERR;
  logic [W-1:0] TX_DATA, RX_DATA, SR_D, SR_Q;
  logic         DIR_CFG, SER_IN, SER_OUT, SER_OE, BUSY;
  logic [1:0]   SR_MODO;
  logic         SR_ENB, SR_DIR, SR_S_IN, SR_S_OUT;

  s2p_frame_ctrl #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET_L(RESET_L),
    .TX_VALID(TX_VALID), .TX_DATA(TX_DATA), .TX_READY(TX_READY),
    .RX_REQ(RX_REQ), .RX_VALID(RX_VALID), .RX_DATA(RX_DATA),
    .RX_PERR(RX_PERR), .DIR_CFG(DIR_CFG), .SER_IN(SER_IN),
    .SER_OUT(SER_OUT), .SER_OE(SER_OE), .BUSY(BUSY),
    .SR_D(SR_D), .SR_MODO(SR_MODO), .SR_ENB(SR_ENB),
    .SR_DIR(SR_DIR), .SR_S_IN(SR_S_IN),
    .SR_Q(SR_Q), .SR_S_OUT(SR_S_OUT)
  );

  always #5 CLK = ~CLK;

  // s2p_cond stand-in: S_OUT registers the bit leaving on each push
  logic [W-1:0] sr_q;
  logic         sr_sout;
  assign SR_Q     = sr_q;
  assign SR_S_OUT = sr_sout;
  always @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      sr_q    <= '0;
      sr_sout <= 1'b0;
    end else if (SR_ENB) begin
      if (SR_MODO == MODO_LOAD) sr_q <= SR_D;
      else if (SR_MODO == MODO_PUSH) begin
        if (SR_DIR) begin
          sr_sout <= sr_q[0];
          sr_q    <= {SR_S_IN, sr_q[W-1:1]};
        end else begin
          sr_sout <= sr_q[W-1];
          sr_q    <= {sr_q[W-2:0], SR_S_IN};
        end
      end else sr_q <= {sr_q[W-2:0], sr_q[W-1]};
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Reference model: each grant fixes the frame's whole timeline
  int           free_at = 0, busy_from = 1, busy_to = 0;
  int           oe_from = 1, oe_to = 0, rx_g = 0, valid_at = -1;
  logic [W-1:0] tx_word = '0, rx_acc = '0, exp_rx = '0;
  logic         tx_dir = 0, rx_dir = 0, rx_on = 0, pbit = 0;
  logic         exp_perr = 0, last_rx = 1;

  // Observation counters for the directed tests
  logic [63:0]  cap;
  int           cap_n, busy_cnt, ready_cnt, valid_cnt;
  logic         last_perr;

  always @(negedge CLK) begin
    logic gtx, grx, e_busy, e_oe, e_valid, e_bit;
    int   k;
    gtx = 1'b0;
    grx = 1'b0;
    if (!RESET_L) begin
      free_at  = cyc;
      busy_from = 1; busy_to = 0;
      oe_from  = 1;  oe_to = 0;
      valid_at = -1;
      rx_on    = 1'b0;
      exp_rx   = '0;
      exp_perr = 1'b0;
      last_rx  = 1'b1;
    end else begin
      if (rx_on && cyc >= rx_g + 1 && cyc <= rx_g + W)
        rx_acc = rx_dir ? {SER_IN, rx_acc[W-1:1]}
                        : {rx_acc[W-2:0], SER_IN};
      if (rx_on && P == 1 && cyc == rx_g + W + 1) pbit = SER_IN;
      if (cyc == valid_at) begin
        exp_rx   = rx_acc;
        exp_perr = (P == 1) ? (pbit ^ (^rx_acc)) : 1'b0;
        rx_on    = 1'b0;
      end
      if (cyc >= free_at) begin
        gtx = TX_VALID && (!RX_REQ || last_rx);
        grx = RX_REQ && !gtx;
      end
    end
    e_busy  = (cyc >= busy_from) && (cyc <= busy_to);
    e_oe    = (cyc >= oe_from) && (cyc <= oe_to);
    e_valid = (cyc == valid_at);
    chk("tx_ready", 32'(TX_READY), 32'(gtx));
    chk("busy", 32'(BUSY), 32'(e_busy));
    chk("ser_oe", 32'(SER_OE), 32'(e_oe));
    chk("rx_valid", 32'(RX_VALID), 32'(e_valid));
    chk("rx_data", 32'(RX_DATA), 32'(exp_rx));
    chk("modo_cycle", 32'(SR_MODO == MODO_CYCLE), 32'd0);
    if (e_valid) chk("rx_perr", 32'(RX_PERR), 32'(exp_perr));
    if (e_oe) begin
      k = cyc - oe_from;
      if (k < W) e_bit = tx_dir ? tx_word[k] : tx_word[W-1-k];
      else       e_bit = ^tx_word;
      chk("ser_out", 32'(SER_OUT), 32'(e_bit));
    end
    if (SER_OE) begin
      cap = {cap[62:0], SER_OUT};
      cap_n++;
    end
    if (BUSY) busy_cnt++;
    if (TX_READY) ready_cnt++;
    if (RX_VALID) begin
      valid_cnt++;
      last_perr = RX_PERR;
    end
    if (gtx) begin
      tx_word   = TX_DATA;
      tx_dir    = DIR_CFG;
      busy_from = cyc + 1;
      busy_to   = cyc + W + 1 + P;
      oe_from   = cyc + 3;
      oe_to     = cyc + W + 2 + P;
      free_at   = cyc + FL;
      last_rx   = 1'b0;
    end else if (grx) begin
      rx_g      = cyc;
      rx_dir    = DIR_CFG;
      rx_on     = 1'b1;
      rx_acc    = '0;
      busy_from = cyc + 1;
      busy_to   = cyc + W + 1 + P;
      valid_at  = cyc + FL;
      free_at   = cyc + FL;
      last_rx   = 1'b1;
    end
  end

  task automatic clr();
    cap = '0; cap_n = 0; busy_cnt = 0;
    ready_cnt = 0; valid_cnt = 0; last_perr = 1'b0;
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((BUSY || SER_OE || RX_VALID) && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL quiet_timeout: got busy after %0d cycles", n);
    end
    @(posedge CLK); #1;
  endtask

  task automatic tx_frame(input logic [W-1:0] d, input logic dir);
    int n = 0;
    TX_VALID = 1'b1; TX_DATA = d; DIR_CFG = dir;
    @(negedge CLK);
    while (!TX_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL tx_accept_timeout: got no TX_READY in %0d", n);
    end
    @(posedge CLK); #1;
    TX_VALID = 1'b0;
    wait_quiet();
  endtask

  task automatic rx_frame(input logic [W-1:0] b, input logic dir,
                          input logic pb);
    RX_REQ = 1'b1; DIR_CFG = dir;
    @(posedge CLK); #1;
    RX_REQ = 1'b0;
    for (int i = 0; i < W; i++) begin
      SER_IN = b[W-1-i];
      @(posedge CLK); #1;
    end
    if (P == 1) begin
      SER_IN = pb;
      @(posedge CLK); #1;
    end
    SER_IN = 1'b0;
    wait_quiet();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1);
  end

  initial begin
    RESET_L = 1'b0; TX_VALID = 1'b0; TX_DATA = '0; RX_REQ = 1'b0;
    DIR_CFG = 1'b0; SER_IN = 1'b0;
    clr();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_enb", 32'(SR_ENB), 32'd0);
    chk("rst_modo", 32'(SR_MODO), 32'(MODO_LOAD));
    chk("rst_d", 32'(SR_D), 32'd0);
    chk("rst_dir", 32'(SR_DIR), 32'd0);
    chk("rst_sin", 32'(SR_S_IN), 32'd0);
    chk("rst_oe", 32'(SER_OE), 32'd0);
    chk("rst_rxd", 32'(RX_DATA), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    RESET_L = 1'b1;
    @(posedge CLK); #1;

    clr(); tx_frame(8'hA5, 1'b0);
    chk("a5_msb_bits", 32'(cap >> P), 32'hA5);
    chk("a5_msb_n", 32'(cap_n), 32'(W + P));
    chk("a5_busy_n", 32'(busy_cnt), 32'(W + 1 + P));
    chk("a5_ready_n", 32'(ready_cnt), 32'd1);

    clr(); tx_frame(8'hA5, 1'b1);
    chk("a5_lsb_bits", 32'(cap >> P), 32'hA5);
    clr(); tx_frame(8'h01, 1'b1);
    chk("01_lsb_bits", 32'(cap >> P), 32'h80);

    clr(); rx_frame(8'hC3, 1'b0, 1'b0);
    chk("rx_c3", 32'(RX_DATA), 32'hC3);
    chk("rx_c3_valid_n", 32'(valid_cnt), 32'd1);
    chk("rx_c3_oe_n", 32'(cap_n), 32'd0);

    RESET_L = 1'b0;
    @(posedge CLK); #1;
    RESET_L = 1'b1;
    @(posedge CLK); #1;
    clr();
    TX_VALID = 1'b1; TX_DATA = 8'h96; RX_REQ = 1'b1; SER_IN = 1'b1;
    repeat (2 * FL + 1) @(posedge CLK);
    #1;
    TX_VALID = 1'b0; RX_REQ = 1'b0; SER_IN = 1'b0;
    wait_quiet();
    chk("alt_ready_n", 32'(ready_cnt), 32'd2);
    chk("alt_valid_n", 32'(valid_cnt), 32'd1);
    chk("alt_rx_data", 32'(RX_DATA), 32'hFF);

    clr();
    TX_VALID = 1'b1; TX_DATA = 8'h5A; DIR_CFG = 1'b0;
    #1;
    chk("mid_ready", 32'(TX_READY), 32'd1);
    @(posedge CLK); #1;
    TX_VALID = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    chk("mid_oe_on", 32'(SER_OE), 32'd1);
    RESET_L = 1'b0;
    #1;
    chk("mid_rst_enb", 32'(SR_ENB), 32'd0);
    chk("mid_rst_oe", 32'(SER_OE), 32'd0);
    chk("mid_rst_busy", 32'(BUSY), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RESET_L = 1'b1;
    @(posedge CLK); #1;
    chk("mid_no_valid", 32'(valid_cnt), 32'd0);
    clr(); tx_frame(8'h3C, 1'b0);
    chk("post_rst_bits", 32'(cap >> P), 32'h3C);

`ifdef S2P_FRAME_CTRL_PARITY_EN
    clr(); tx_frame(8'h07, 1'b0);
    chk("par_07_bits", 32'(cap), 32'h00F);
    clr(); rx_frame(8'hFF, 1'b0, 1'b1);
    chk("par_perr_1", 32'(last_perr), 32'd1);
    clr(); rx_frame(8'hFF, 1'b0, 1'b0);
    chk("par_perr_0", 32'(last_perr), 32'd0);
`endif

    for (int i = 0; i < 3000; i++) begin
      TX_VALID = ($urandom_range(0, 3) == 0);
      RX_REQ   = ($urandom_range(0, 3) == 0);
      TX_DATA  = W'($urandom);
      DIR_CFG  = $urandom_range(0, 1) == 1;
      SER_IN   = $urandom_range(0, 1) == 1;
      @(posedge CLK); #1;
    end
    TX_VALID = 1'b0; RX_REQ = 1'b0; SER_IN = 1'b0;
    wait_quiet();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/s2p_frame_ctrl.md
Name: s2p_frame_ctrl

Overview:
- Sequencer and arbiter for one shared s2p_cond shift register, used half-duplex by a parallel transmit requester and a serial receive requester.
- Drives the register's D/MODO/ENB/DIR/S_IN pins and observes its Q/S_OUT.
- A TX frame is one LOAD followed by WIDTH PUSH cycles. An RX frame is WIDTH PUSH cycles sampling SER_IN, then handoff of the captured word.

Parameters:
- WIDTH, 8, frame/word width. Must match the attached s2p_cond; legal range 2..32.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RESET_L  in  1  asynchronous, active-low reset.
- TX_VALID  in  1  TX word pending.
- TX_DATA  in  WIDTH  TX word; captured when TX_VALID && TX_READY.
- TX_READY  out  1  TX accept strobe.
- RX_REQ  in  1  request to receive one frame; level, sampled in IDLE.
- RX_VALID  out  1  one-cycle pulse, RX_DATA is new.
- RX_DATA  out  WIDTH  last received word.
- RX_PERR  out  1  parity error, qualified by RX_VALID.
- DIR_CFG  in  1  shift direction for the next granted frame (0 = MSB first).
- SER_IN  in  1  serial receive line.
- SER_OUT  out  1  serial transmit line; equals SR_S_OUT.
- SER_OE  out  1  SER_OUT carries a valid bit.
- BUSY  out  1  state != IDLE.
- SR_D  out  WIDTH  to register D.
- SR_MODO  out  2  to register MODO.
- SR_ENB  out  1  to register ENB.
- SR_DIR  out  1  to register DIR.
- SR_S_IN  out  1  to register S_IN.
- SR_Q  in  WIDTH  from register Q.
- SR_S_OUT  in  1  from register S_OUT.

Behaviour:
- Reset (async, RESET_L=0) forces:
  - state=IDLE, cnt=0, last_grant=RX, so TX wins the first tie;
  - TX_READY=0, RX_VALID=0, RX_DATA=0, RX_PERR=0, SER_OE=0;
  - SR_ENB=0, SR_MODO=`LOAD, SR_D=0, SR_DIR=0, SR_S_IN=0.
  - Reset mid-frame abandons the frame; no RX_VALID is issued.
- States: IDLE, LOAD, SHIFT_TX, SHIFT_RX, PAR (only with the option), DONE_RX.
- IDLE: SR_ENB=0.
  - TX_VALID only: grant TX.
  - RX_REQ only: grant RX.
  - Both: grant the side not equal to last_grant, then update last_grant.
  - TX grant: TX_READY=1 for that cycle (combinational from state and arbitration); TX_DATA captured into tx_buf; dir_lat<=DIR_CFG; next state LOAD.
  - RX grant: dir_lat<=DIR_CFG; cnt<=0; next state SHIFT_RX.
- LOAD (1 cycle): SR_MODO=`LOAD, SR_D=tx_buf, SR_ENB=1; next state SHIFT_TX, cnt<=0.
- SHIFT_TX: SR_MODO=`PUSH, SR_ENB=1, SR_DIR=dir_lat, SR_S_IN=0.
  - cnt increments each cycle.
  - On the cycle with cnt==WIDTH-1, go to PAR if enabled, else IDLE.
- SHIFT_RX: same as SHIFT_TX but SR_S_IN=SER_IN. After WIDTH cycles go to PAR if enabled, else DONE_RX.
- DONE_RX (1 cycle): RX_DATA<=SR_Q on exit; RX_VALID pulses high in the following cycle, which is IDLE.
- SER_OE:
  - Set on the edge performing the 1st TX PUSH.
  - Cleared on the edge after the WIDTH-th PUSH (or after the PAR cycle when enabled).
  - Net effect: exactly WIDTH (or WIDTH+1) high cycles, the last of which overlaps IDLE.
  - Never set for RX frames.
- A new grant may occur in the IDLE cycle where SER_OE is still high. The LOAD edge then clears SER_OE.
- There is always one IDLE cycle between frames.
- TX frame latency is 2+WIDTH cycles from TX accept to SER_OE fall.
- SR_MODO never takes `CYCLE; the controller issues no rotate operation.

Optional Feature:
- Macro: S2P_FRAME_CTRL_PARITY_EN.
- Defined, TX: the PAR state adds one cycle with SR_ENB=0. SER_OUT is muxed to the even parity of tx_buf, and SER_OE stays high.
- Defined, RX: the PAR state samples SER_IN. RX_PERR = SER_IN xor (^SR_Q), registered with RX_DATA.
- Undefined: no PAR state; SER_OUT=SR_S_OUT always; RX_PERR tied 0.

Decomposition:
- The shared definitions.v supplies the `PUSH/`CYCLE/`LOAD MODO codes.
- Add to it the state encodings and the grant encodings (GRANT_TX, GRANT_RX).
- Natural sub-module: s2p_frame_arb, the 2-way round-robin arbiter holding last_grant.

Test Plan:
- TX 8'hA5, DIR_CFG=0 → TX_READY one cycle, LOAD, then SER_OUT=1,0,1,0,0,1,0,1 across the 8 SER_OE cycles; BUSY high for 9 cycles.
- TX 8'hA5, DIR_CFG=1 → SER_OUT=1,0,1,0,0,1,0,1 LSB first (palindrome check), then 8'h01 → 1,0,0,0,0,0,0,0.
- RX_REQ with SER_IN=1,1,0,0,0,0,1,1, DIR_CFG=0 → RX_VALID single pulse with RX_DATA=8'hC3; SER_OE stays 0.
- TX_VALID and RX_REQ held together → grants alternate TX, RX, TX; TX_READY pulses count 2, RX_VALID pulses count 1 after 3 frames.
- RESET_L dropped at SHIFT_TX cnt=4 → SR_ENB=0 and SER_OE=0 immediately; no RX_VALID; a new TX after release completes normally.
- With PARITY_EN: TX 8'h07 → 9th SER_OE bit =1. RX 8'hFF followed by SER_IN=1 → RX_PERR=1; followed by 0 → RX_PERR=0.
